// File: rtl/rr_sel3_gen.sv
// -----------------------------------------------------------------------------
// rr_sel3_gen
//
// Three-way round-robin arbiter that produces registered one-hot select lines
// for a downstream AO222 and-or mux. gnt[0]/gnt[1]/gnt[2] drive the AO222
// IN2/IN4/IN6 pins; din0/din1/din2 drive IN1/IN3/IN5. A local copy of the
// and-or result is also exposed as dout, qualified by valid_out/ready_in.
//
// A hold-timeout counter force-releases a grant whose sink never accepts, so a
// stalled consumer cannot lock the mux onto a single requester.
//
// Parameters
//   W         data width per requester
//   HOLD_MAX  max cycles a grant waits for ready_in before forced release;
//             0 disables the timeout
//
// Ports
//   clk        in   1  rising-edge clock
//   rstb       in   1  asynchronous active-low reset
//   req        in   3  request per requester, held until ack
//   din0..2    in   W  requester data
//   ready_in   in   1  sink accepts dout this cycle
//   gnt        out  3  registered one-hot (or zero) mux select
//   valid_out  out  1  dout valid, equals |gnt
//   dout       out  W  and-or of the selected data (combinational from gnt)
//   ack        out  3  1-cycle pulse to the requester whose transfer was taken
//   timeout    out  1  1-cycle pulse when a grant is force-released
// -----------------------------------------------------------------------------
module rr_sel3_gen #(
  parameter int W        = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [2:0]   req,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic         ready_in,
  output logic [2:0]   gnt,
  output logic         valid_out,
  output logic [W-1:0] dout,
  output logic [2:0]   ack,
  output logic         timeout
);

  // Hold counter only needs to reach HOLD_MAX-1; keep at least one bit so the
  // design still elaborates when the timeout is disabled.
  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam bit HOLD_EN = (HOLD_MAX != 0);
  localparam logic [CW-1:0] HCNT_LAST = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_reg;
  logic [2:0]    gnt_reg;
  logic [1:0]    ptr_reg;
  logic [CW-1:0] hcnt_reg;
  logic [2:0]    ack_reg;
  logic          timeout_reg;

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate the request vector so the priority pointer lands
  // on bit 0, isolate the lowest set bit, then rotate back. ptr is only ever
  // 0..2; the default arm also covers the unreachable value 3.
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] rot;
    logic [2:0] sel;
    logic [2:0] res;
    case (p)
      2'd1:    rot = {r[0], r[2], r[1]};
      2'd2:    rot = {r[1], r[0], r[2]};
      default: rot = r;
    endcase
    sel = rot & (~rot + 3'd1);
    case (p)
      2'd1:    res = {sel[1], sel[0], sel[2]};
      2'd2:    res = {sel[0], sel[2], sel[1]};
      default: res = sel;
    endcase
    return res;
  endfunction

  // Index of the current grant and the pointer value that follows it.
  logic [1:0] gnt_idx;
  logic [1:0] ptr_after;

  always_comb begin
    gnt_idx = 2'd0;
    if (gnt_reg[1]) gnt_idx = 2'd1;
    if (gnt_reg[2]) gnt_idx = 2'd2;
  end

  assign ptr_after = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;

  // Fresh decision from IDLE, and the back-to-back decision taken on accept:
  // the requester just served is masked out for that one decision, and the
  // search starts after it.
  logic [2:0] idle_pick;
  logic [2:0] next_pick;

  assign idle_pick = rr_pick(req, ptr_reg);
  assign next_pick = rr_pick(req & ~gnt_reg, ptr_after);

  // Busy-state events, in decreasing priority.
  logic req_held;
  logic do_accept;
  logic do_abort;
  logic do_timeout;

  assign req_held   = |(req & gnt_reg);
  assign do_accept  = ready_in;
  assign do_abort   = !req_held && !ready_in;
  assign do_timeout = HOLD_EN && (hcnt_reg == HCNT_LAST);

  // ---------------------------------------------------------------------------
  // Arbiter state machine. All outputs that feed the mux select are registered
  // so the select lines only move on clock edges.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg   <= IDLE;
      gnt_reg     <= 3'b000;
      ptr_reg     <= 2'd0;
      hcnt_reg    <= '0;
      ack_reg     <= 3'b000;
      timeout_reg <= 1'b0;
    end else begin
      // Pulses default low every cycle.
      ack_reg     <= 3'b000;
      timeout_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          hcnt_reg <= '0;
          gnt_reg  <= idle_pick;
          if (|req) begin
            state_reg <= BUSY;
          end
        end

        BUSY: begin
          if (do_accept) begin
            ack_reg   <= gnt_reg;
            ptr_reg   <= ptr_after;
            hcnt_reg  <= '0;
            gnt_reg   <= next_pick;
            state_reg <= (|next_pick) ? BUSY : IDLE;
          end else if (do_abort) begin
            // Requester withdrew: drop the grant, leave priority where it was.
            gnt_reg   <= 3'b000;
            hcnt_reg  <= '0;
            state_reg <= IDLE;
          end else if (do_timeout) begin
            // Stalled sink: release and move priority past the stuck requester.
            gnt_reg     <= 3'b000;
            timeout_reg <= 1'b1;
            ptr_reg     <= ptr_after;
            hcnt_reg    <= '0;
            state_reg   <= IDLE;
          end else if (HOLD_EN && (hcnt_reg != {CW{1'b1}})) begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 3'b000;
          hcnt_reg  <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Local and-or mux mirroring the AO222: each lane is gated by its own select.
  // ---------------------------------------------------------------------------
  logic [W-1:0] din_arr  [3];
  logic [W-1:0] lane_arr [3];

  assign din_arr[0] = din0;
  assign din_arr[1] = din1;
  assign din_arr[2] = din2;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_arr[gi] = din_arr[gi] & {W{gnt_reg[gi]}};
    end
  endgenerate

  assign dout      = lane_arr[0] | lane_arr[1] | lane_arr[2];
  assign gnt       = gnt_reg;
  assign valid_out = |gnt_reg;
  assign ack       = ack_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_sel3_gen.sv
// -----------------------------------------------------------------------------
// tb_rr_sel3_gen
//
// Directed-vector bench for rr_sel3_gen (HOLD_MAX=4). The stimulus process
// drives one cycle of inputs per step and queues the hand-computed outputs
// expected after that clock edge; a separate monitor pops and compares the
// queue on each falling clock edge, or right after an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_rr_sel3_gen;

  logic       clk;
  logic       rstb;
  logic [2:0] req;
  logic [7:0] din0;
  logic [7:0] din1;
  logic [7:0] din2;
  logic       ready_in;
  logic [2:0] gnt;
  logic       valid_out;
  logic [7:0] dout;
  logic [2:0] ack;
  logic       timeout;

  int checks;
  int errors;

  typedef struct packed {
    logic [2:0] gnt;
    logic       vld;
    logic [7:0] dout;
    logic [2:0] ack;
    logic       to;
  } obs_t;

  obs_t exp_q[$];
  int   tid_q[$];

  rr_sel3_gen #(
    .W        (8),
    .HOLD_MAX (4)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .req       (req),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .ready_in  (ready_in),
    .gnt       (gnt),
    .valid_out (valid_out),
    .dout      (dout),
    .ack       (ack),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic step(input int tid, input logic [2:0] r, input logic rdy,
                      input logic [2:0] eg, input logic [7:0] ed,
                      input logic [2:0] ea, input logic et);
    obs_t e;
    req      = r;
    ready_in = rdy;
    @(posedge clk);
    #1;
    e.gnt  = eg;
    e.vld  = |eg;
    e.dout = ed;
    e.ack  = ea;
    e.to   = et;
    exp_q.push_back(e);
    tid_q.push_back(tid);
    $display("step %0d: req=%b rdy=%b -> expect gnt=%b dout=%h ack=%b to=%b",
             tid, r, rdy, eg, ed, ea, et);
  endtask

  // Monitor / scoreboard.
  initial begin
    obs_t e;
    obs_t a;
    int   t;
    forever begin
      @(negedge clk or negedge rstb);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tid_q.pop_front();
        a.gnt  = gnt;
        a.vld  = valid_out;
        a.dout = dout;
        a.ack  = ack;
        a.to   = timeout;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL step%0d: got gnt=%b vld=%b dout=%h ack=%b to=%b, want gnt=%b vld=%b dout=%h ack=%b to=%b",
                   t, a.gnt, a.vld, a.dout, a.ack, a.to, e.gnt, e.vld, e.dout, e.ack, e.to);
        end
      end
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t e;
    checks   = 0;
    errors   = 0;
    rstb     = 1'b0;
    req      = 3'b000;
    ready_in = 1'b0;
    din0     = 8'h11;
    din1     = 8'h22;
    din2     = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;

    // Idle after reset: nothing granted.
    for (int i = 0; i < 5; i++) step(i, 3'b000, 1'b0, 3'b000, 8'h00, 3'b000, 1'b0);

    // All requesting, sink always ready: 0,1,2,0 back-to-back.
    step(5,  3'b111, 1'b1, 3'b001, 8'h11, 3'b000, 1'b0);
    step(6,  3'b111, 1'b1, 3'b010, 8'h22, 3'b001, 1'b0);
    step(7,  3'b111, 1'b1, 3'b100, 8'h33, 3'b010, 1'b0);
    step(8,  3'b111, 1'b1, 3'b001, 8'h11, 3'b100, 1'b0);
    step(9,  3'b000, 1'b1, 3'b000, 8'h00, 3'b001, 1'b0);   // ptr -> 1

    // Requester 1 alone, sink stalls 3 cycles then accepts; accept beats the
    // coinciding timeout on the fourth cycle.
    step(10, 3'b010, 1'b0, 3'b010, 8'h22, 3'b000, 1'b0);
    step(11, 3'b010, 1'b0, 3'b010, 8'h22, 3'b000, 1'b0);
    step(12, 3'b010, 1'b0, 3'b010, 8'h22, 3'b000, 1'b0);
    step(13, 3'b010, 1'b0, 3'b010, 8'h22, 3'b000, 1'b0);
    step(14, 3'b010, 1'b1, 3'b000, 8'h00, 3'b010, 1'b0);   // ptr -> 2

    // Requester 0 with a dead sink: 4 cycles of grant, then timeout.
    step(15, 3'b001, 1'b0, 3'b001, 8'h11, 3'b000, 1'b0);
    step(16, 3'b001, 1'b0, 3'b001, 8'h11, 3'b000, 1'b0);
    step(17, 3'b001, 1'b0, 3'b001, 8'h11, 3'b000, 1'b0);
    step(18, 3'b001, 1'b0, 3'b001, 8'h11, 3'b000, 1'b0);
    step(19, 3'b001, 1'b0, 3'b000, 8'h00, 3'b000, 1'b1);   // ptr -> 1

    // After the timeout requester 1 is favoured over 0.
    step(20, 3'b011, 1'b0, 3'b010, 8'h22, 3'b000, 1'b0);
    step(21, 3'b011, 1'b1, 3'b001, 8'h11, 3'b010, 1'b0);
    step(22, 3'b001, 1'b1, 3'b000, 8'h00, 3'b001, 1'b0);   // ptr -> 1

    // Abort: requester 2 drops its request, no ack/timeout, ptr stays 1.
    step(23, 3'b100, 1'b0, 3'b100, 8'h33, 3'b000, 1'b0);
    step(24, 3'b000, 1'b0, 3'b000, 8'h00, 3'b000, 1'b0);
    step(25, 3'b111, 1'b0, 3'b010, 8'h22, 3'b000, 1'b0);

    // Asynchronous reset mid-grant, between clock edges.
    e = '0;
    exp_q.push_back(e);
    tid_q.push_back(26);
    $display("step 26: async reset mid-grant -> expect all outputs zero");
    @(negedge clk);
    #2;
    rstb = 1'b0;
    #6;
    rstb = 1'b1;

    // Arbitration restarts from requester 0.
    step(27, 3'b111, 1'b1, 3'b001, 8'h11, 3'b000, 1'b0);
    step(28, 3'b111, 1'b1, 3'b010, 8'h22, 3'b001, 1'b0);
    step(29, 3'b000, 1'b1, 3'b000, 8'h00, 3'b010, 1'b0);
    step(30, 3'b000, 1'b0, 3'b000, 8'h00, 3'b000, 1'b0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
